// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: request-driven road/pedestrian lamp sequencer.
// Optional night flashing mode is compiled in with macro PED_CROSSING_NIGHT_FLASH_EN.
module ped_crossing_ctrl #(
    parameter int N_BTN           = 2,
    parameter int CNT_W           = 8,
    parameter int T_CAR_GREEN_MIN = 5,
    parameter int T_CAR_YELLOW    = 1,
    parameter int T_ALL_RED       = 2,
    parameter int T_PED_GREEN     = 4,
    parameter int T_PED_BLINK     = 4,
    parameter int T_RED_YELLOW    = 1,
    parameter int BLINK_HALF      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [N_BTN-1:0] ped_req,
`ifdef PED_CROSSING_NIGHT_FLASH_EN
    input  logic             night_mode,
`endif
    output logic             road_red,
    output logic             road_yellow,
    output logic             road_green,
    output logic             ped_red,
    output logic             ped_green,
    output logic             req_pending
);

    typedef enum logic [2:0] {
        CAR_GREEN,
        CAR_YELLOW,
        ALL_RED_1,
        PED_GREEN,
        PED_BLINK,
        ALL_RED_2,
        CAR_RED_YELLOW
`ifdef PED_CROSSING_NIGHT_FLASH_EN
        , NIGHT
`endif
    } state_e;

    localparam logic [CNT_W-1:0] LD_CAR_GREEN  = CNT_W'(T_CAR_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] LD_CAR_YELLOW = CNT_W'(T_CAR_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALL_RED    = CNT_W'(T_ALL_RED - 1);
    localparam logic [CNT_W-1:0] LD_PED_GREEN  = CNT_W'(T_PED_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_PED_BLINK  = CNT_W'(T_PED_BLINK - 1);
    localparam logic [CNT_W-1:0] LD_RED_YELLOW = CNT_W'(T_RED_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_BLINK      = CNT_W'(BLINK_HALF - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             req_q, req_d;
    logic             blink_q, blink_d;
    logic             expired;
    logic             latch_en;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CAR_GREEN;
            cnt_q   <= LD_CAR_GREEN;
            bcnt_q  <= LD_BLINK;
            req_q   <= 1'b0;
            blink_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            req_q   <= req_d;
            blink_q <= blink_d;
        end
    end

    assign expired = tick && (cnt_q == '0);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        blink_d  = blink_q;
        latch_en = 1'b1;

        // Counter saturates at zero, which is how CAR_GREEN waits for a request.
        if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        unique case (state_q)
            PED_GREEN, PED_BLINK: latch_en = 1'b0;
`ifdef PED_CROSSING_NIGHT_FLASH_EN
            NIGHT:                latch_en = 1'b0;
`endif
            default:              latch_en = 1'b1;
        endcase
        req_d = req_q | (latch_en & (|ped_req));

        if ((state_q == PED_BLINK)
`ifdef PED_CROSSING_NIGHT_FLASH_EN
            || (state_q == NIGHT)
`endif
           ) begin
            if (tick) begin
                if (bcnt_q == '0) begin
                    blink_d = ~blink_q;
                    bcnt_d  = LD_BLINK;
                end else begin
                    bcnt_d  = bcnt_q - CNT_W'(1);
                end
            end
        end

        case (state_q)
            CAR_GREEN: begin
`ifdef PED_CROSSING_NIGHT_FLASH_EN
                if (tick && night_mode) begin
                    state_d = NIGHT;
                    blink_d = 1'b1;
                    bcnt_d  = LD_BLINK;
                    req_d   = 1'b0;
                end else
`endif
                if (expired && req_q) begin
                    state_d = CAR_YELLOW;
                    cnt_d   = LD_CAR_YELLOW;
                end
            end
            CAR_YELLOW: if (expired) begin
                state_d = ALL_RED_1;
                cnt_d   = LD_ALL_RED;
            end
            ALL_RED_1: if (expired) begin
                state_d = PED_GREEN;
                cnt_d   = LD_PED_GREEN;
                req_d   = 1'b0;
            end
            PED_GREEN: if (expired) begin
                state_d = PED_BLINK;
                cnt_d   = LD_PED_BLINK;
                blink_d = 1'b1;
                bcnt_d  = LD_BLINK;
            end
            PED_BLINK: if (expired) begin
                state_d = ALL_RED_2;
                cnt_d   = LD_ALL_RED;
            end
            ALL_RED_2: if (expired) begin
                state_d = CAR_RED_YELLOW;
                cnt_d   = LD_RED_YELLOW;
            end
            CAR_RED_YELLOW: if (expired) begin
                state_d = CAR_GREEN;
                cnt_d   = LD_CAR_GREEN;
            end
`ifdef PED_CROSSING_NIGHT_FLASH_EN
            NIGHT: begin
                req_d = 1'b0;
                if (tick && !night_mode) begin
                    state_d = ALL_RED_2;
                    cnt_d   = LD_ALL_RED;
                end
            end
`endif
            default: begin
                state_d = CAR_GREEN;
                cnt_d   = LD_CAR_GREEN;
            end
        endcase
    end

    always_comb begin
        road_red    = 1'b0;
        road_yellow = 1'b0;
        road_green  = 1'b0;
        ped_red     = 1'b0;
        ped_green   = 1'b0;
        case (state_q)
            CAR_GREEN:      begin road_green = 1'b1; ped_red = 1'b1; end
            CAR_YELLOW:     begin road_yellow = 1'b1; ped_red = 1'b1; end
            ALL_RED_1,
            ALL_RED_2:      begin road_red = 1'b1; ped_red = 1'b1; end
            PED_GREEN:      begin road_red = 1'b1; ped_green = 1'b1; end
            PED_BLINK:      begin road_red = 1'b1; ped_green = blink_q; end
            CAR_RED_YELLOW: begin road_red = 1'b1; road_yellow = 1'b1; ped_red = 1'b1; end
`ifdef PED_CROSSING_NIGHT_FLASH_EN
            NIGHT:          road_yellow = blink_q;
`endif
            default:        begin road_red = 1'b1; ped_red = 1'b1; end
        endcase
    end

    assign req_pending = req_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed self-checking bench for ped_crossing_ctrl with default parameters.
// Night mode scenario runs only when PED_CROSSING_NIGHT_FLASH_EN is defined.
module tb_ped_crossing_ctrl;

    // Lamp vector order: {road_red, road_yellow, road_green, ped_red, ped_green}
    localparam logic [4:0] L_CG     = 5'b00110;
    localparam logic [4:0] L_CY     = 5'b01010;
    localparam logic [4:0] L_AR     = 5'b10010;
    localparam logic [4:0] L_PB_ON  = 5'b10001;
    localparam logic [4:0] L_PB_OFF = 5'b10000;
    localparam logic [4:0] L_PG     = 5'b10001;
    localparam logic [4:0] L_CRY    = 5'b11010;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] ped_req = 2'b00;
`ifdef PED_CROSSING_NIGHT_FLASH_EN
    logic       night_mode = 1'b0;
`endif
    logic road_red, road_yellow, road_green, ped_red, ped_green, req_pending;
    logic [4:0] lamps;

    int checks = 0;
    int errors = 0;

    ped_crossing_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .ped_req     (ped_req),
`ifdef PED_CROSSING_NIGHT_FLASH_EN
        .night_mode  (night_mode),
`endif
        .road_red    (road_red),
        .road_yellow (road_yellow),
        .road_green  (road_green),
        .ped_red     (ped_red),
        .ped_green   (ped_green),
        .req_pending (req_pending)
    );

    assign lamps = {road_red, road_yellow, road_green, ped_red, ped_green};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        tick    = 1'b0;
        ped_req = 2'b00;
`ifdef PED_CROSSING_NIGHT_FLASH_EN
        night_mode = 1'b0;
`endif
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (lamps !== L_CG) begin
            errors++;
            $display("FAIL reset_lamps: got %b expected %b", lamps, L_CG);
        end
        checks++;
        if (req_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_req: got %b expected 0", req_pending);
        end
    endtask

    task automatic test_idle();
        do_reset();
        tick = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            step();
            checks++;
            if (lamps !== L_CG || req_pending !== 1'b0) begin
                errors++;
                $display("FAIL idle_k%0d: lamps %b req %b expected %b req 0", k, lamps, req_pending, L_CG);
            end
        end
    endtask

    task automatic test_crossing();
        logic [4:0] exp_seq [17];
        exp_seq = '{L_CY, L_AR, L_AR, L_PG, L_PG, L_PG, L_PG,
                    L_PB_ON, L_PB_OFF, L_PB_ON, L_PB_OFF,
                    L_AR, L_AR, L_CRY, L_CG, L_CG, L_CG};
        do_reset();
        tick = 1'b1;
        for (int k = 1; k <= 9; k++) step();
        checks++;
        if (req_pending !== 1'b0) begin
            errors++;
            $display("FAIL cross_pre_req: got %b expected 0", req_pending);
        end
        ped_req = 2'b10;
        step();
        ped_req = 2'b00;
        checks++;
        if (req_pending !== 1'b1 || lamps !== L_CG) begin
            errors++;
            $display("FAIL cross_latch: req %b lamps %b expected req 1 lamps %b", req_pending, lamps, L_CG);
        end
        for (int i = 0; i < 17; i++) begin
            step();
            checks++;
            if (lamps !== exp_seq[i]) begin
                errors++;
                $display("FAIL cross_seq_k%0d: got %b expected %b", i + 11, lamps, exp_seq[i]);
            end
            if (i == 3) begin
                checks++;
                if (req_pending !== 1'b0) begin
                    errors++;
                    $display("FAIL cross_req_clear: got %b expected 0", req_pending);
                end
            end
        end
    endtask

    task automatic test_slow_tick();
        logic [4:0] exp_l;
        do_reset();
        for (int k = 1; k <= 60; k++) begin
            tick    = (k % 3 == 0);
            ped_req = (k == 2) ? 2'b01 : 2'b00;
            step();
            if      (k < 15) exp_l = L_CG;
            else if (k < 18) exp_l = L_CY;
            else if (k < 24) exp_l = L_AR;
            else if (k < 36) exp_l = L_PG;
            else if (k < 48) exp_l = ((((k - 36) / 3) % 2) == 0) ? L_PB_ON : L_PB_OFF;
            else if (k < 54) exp_l = L_AR;
            else if (k < 57) exp_l = L_CRY;
            else             exp_l = L_CG;
            checks++;
            if (lamps !== exp_l) begin
                errors++;
                $display("FAIL slow_k%0d: got %b expected %b", k, lamps, exp_l);
            end
            checks++;
            if ((road_green && ped_green) || (ped_red && ped_green)) begin
                errors++;
                $display("FAIL slow_conflict_k%0d: lamps %b expected no conflict", k, lamps);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_l;
        logic       exp_r;
        do_reset();
        tick    = 1'b1;
        ped_req = 2'b11;
        for (int k = 1; k <= 24; k++) begin
            step();
            if      (k <= 4)  exp_l = L_CG;
            else if (k == 5)  exp_l = L_CY;
            else if (k <= 7)  exp_l = L_AR;
            else if (k <= 11) exp_l = L_PG;
            else if (k <= 15) exp_l = (k % 2 == 0) ? L_PB_ON : L_PB_OFF;
            else if (k <= 17) exp_l = L_AR;
            else if (k == 18) exp_l = L_CRY;
            else if (k <= 23) exp_l = L_CG;
            else              exp_l = L_CY;
            exp_r = (k <= 7) || (k >= 17);
            checks++;
            if (lamps !== exp_l || req_pending !== exp_r) begin
                errors++;
                $display("FAIL b2b_k%0d: lamps %b req %b expected lamps %b req %b",
                         k, lamps, req_pending, exp_l, exp_r);
            end
        end
        ped_req = 2'b00;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick    = 1'b1;
        ped_req = 2'b01;
        for (int k = 1; k <= 9; k++) step();
        checks++;
        if (lamps !== L_PG) begin
            errors++;
            $display("FAIL mid_setup: got %b expected %b", lamps, L_PG);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (lamps !== L_CG || req_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: lamps %b req %b expected %b req 0", lamps, req_pending, L_CG);
        end
        ped_req = 2'b00;
        step();
        rst_n   = 1'b1;
        ped_req = 2'b10;
        step();
        ped_req = 2'b00;
        for (int k = 2; k <= 5; k++) begin
            step();
            checks++;
            if (lamps !== ((k == 5) ? L_CY : L_CG)) begin
                errors++;
                $display("FAIL mid_recount_k%0d: got %b expected %b", k, lamps, (k == 5) ? L_CY : L_CG);
            end
        end
    endtask

`ifdef PED_CROSSING_NIGHT_FLASH_EN
    task automatic test_night();
        logic [4:0] exp_seq [8];
        exp_seq = '{5'b01000, 5'b00000, 5'b01000, 5'b00000, L_AR, L_AR, L_CRY, L_CG};
        do_reset();
        tick       = 1'b1;
        night_mode = 1'b1;
        ped_req    = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin
                night_mode = 1'b0;
                ped_req    = 2'b00;
            end
            step();
            checks++;
            if (lamps !== exp_seq[k-1]) begin
                errors++;
                $display("FAIL night_k%0d: got %b expected %b", k, lamps, exp_seq[k-1]);
            end
            if (k <= 4) begin
                checks++;
                if (req_pending !== 1'b0) begin
                    errors++;
                    $display("FAIL night_req_k%0d: got %b expected 0", k, req_pending);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_crossing();
        test_slow_tick();
        test_back_to_back();
        test_reset_mid();
`ifdef PED_CROSSING_NIGHT_FLASH_EN
        test_night();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
